timebase_gen: RTL and testbench

- Parametrised successor to the fixed-rate usec/msec/sec timer.
- Derives single-cycle usec, msec and sec strobes from one clock using a generic prescale ratio.
- Adds a free-running timestamp, enable/clear control and a runtime-programmable interval strobe.
- Sits beside the readout control logic as the board-wide timebase.

---
 rtl/timebase_gen.sv | 169 ++++++++++++++++
 tb/tb_timebase_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timebase_gen.sv
// Board timebase: prescaled usec/msec/sec strobes, free-running timestamp and a
// programmable msec interval strobe. Define TIMEBASE_SNAPSHOT_EN for timestamp capture.
module timebase_gen #(
    parameter int CLK_PER_USEC  = 133,
    parameter int USEC_PER_MSEC = 1000,
    parameter int MSEC_PER_SEC  = 1000,
    parameter int SEC_W         = 32,
    parameter int INT_W         = 16
) (
    input  logic                             clk_133m,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             clr,
    input  logic [INT_W-1:0]                 int_period_ms,
`ifdef TIMEBASE_SNAPSHOT_EN
    input  logic                             snap,
    output logic [SEC_W-1:0]                 snap_sec,
    output logic [$clog2(MSEC_PER_SEC)-1:0]  snap_msec,
    output logic [$clog2(USEC_PER_MSEC)-1:0] snap_usec,
    output logic                             snap_valid,
`endif
    output logic                             usec_tick,
    output logic                             msec_tick,
    output logic                             sec_tick,
    output logic                             int_tick,
    output logic [SEC_W-1:0]                 ts_sec,
    output logic [$clog2(MSEC_PER_SEC)-1:0]  ts_msec,
    output logic [$clog2(USEC_PER_MSEC)-1:0] ts_usec
);

    localparam int PRE_W = $clog2(CLK_PER_USEC);
    localparam int US_W  = $clog2(USEC_PER_MSEC);
    localparam int MS_W  = $clog2(MSEC_PER_SEC);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_USEC - 1);
    localparam logic [US_W-1:0]  US_MAX  = US_W'(USEC_PER_MSEC - 1);
    localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(MSEC_PER_SEC - 1);

    logic [PRE_W-1:0] pre_q,  pre_d;
    logic [US_W-1:0]  us_q,   us_d;
    logic [MS_W-1:0]  ms_q,   ms_d;
    logic [SEC_W-1:0] sec_q,  sec_d;
    logic [INT_W-1:0] icnt_q, icnt_d;
    logic             usec_tick_q, usec_tick_d;
    logic             msec_tick_q, msec_tick_d;
    logic             sec_tick_q,  sec_tick_d;
    logic             int_tick_q,  int_tick_d;

    // One bit wider so that icnt+1 never overflows before comparing with the period.
    logic [INT_W:0]   icnt_inc;
    logic             int_due;

    assign icnt_inc = {1'b0, icnt_q} + {{INT_W{1'b0}}, 1'b1};
    assign int_due  = icnt_inc >= {1'b0, int_period_ms};

    always_comb begin
        pre_d       = pre_q;
        us_d        = us_q;
        ms_d        = ms_q;
        sec_d       = sec_q;
        icnt_d      = icnt_q;
        usec_tick_d = 1'b0;
        msec_tick_d = 1'b0;
        sec_tick_d  = 1'b0;
        int_tick_d  = 1'b0;

        if (clr) begin
            pre_d  = '0;
            us_d   = '0;
            ms_d   = '0;
            sec_d  = '0;
            icnt_d = '0;
        end else if (en) begin
            if (int_period_ms == '0)
                icnt_d = '0;

            if (pre_q == PRE_MAX) begin
                pre_d       = '0;
                usec_tick_d = 1'b1;
                if (us_q == US_MAX) begin
                    us_d        = '0;
                    msec_tick_d = 1'b1;
                    if (ms_q == MS_MAX) begin
                        ms_d       = '0;
                        sec_d      = sec_q + SEC_W'(1);
                        sec_tick_d = 1'b1;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                    // A period shrunk below icnt fires here and restarts from zero.
                    if (int_period_ms != '0) begin
                        if (int_due) begin
                            icnt_d     = '0;
                            int_tick_d = 1'b1;
                        end else begin
                            icnt_d = icnt_inc[INT_W-1:0];
                        end
                    end
                end else begin
                    us_d = us_q + US_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_133m or posedge rst) begin
        if (rst) begin
            pre_q       <= '0;
            us_q        <= '0;
            ms_q        <= '0;
            sec_q       <= '0;
            icnt_q      <= '0;
            usec_tick_q <= 1'b0;
            msec_tick_q <= 1'b0;
            sec_tick_q  <= 1'b0;
            int_tick_q  <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            us_q        <= us_d;
            ms_q        <= ms_d;
            sec_q       <= sec_d;
            icnt_q      <= icnt_d;
            usec_tick_q <= usec_tick_d;
            msec_tick_q <= msec_tick_d;
            sec_tick_q  <= sec_tick_d;
            int_tick_q  <= int_tick_d;
        end
    end

    assign usec_tick = usec_tick_q;
    assign msec_tick = msec_tick_q;
    assign sec_tick  = sec_tick_q;
    assign int_tick  = int_tick_q;
    assign ts_sec    = sec_q;
    assign ts_msec   = ms_q;
    assign ts_usec   = us_q;

`ifdef TIMEBASE_SNAPSHOT_EN
    logic [SEC_W-1:0] snap_sec_q;
    logic [MS_W-1:0]  snap_msec_q;
    logic [US_W-1:0]  snap_usec_q;
    logic             snap_valid_q;

    // Captures the pre-edge timestamp; only rst clears it, clr leaves it alone.
    always_ff @(posedge clk_133m or posedge rst) begin
        if (rst) begin
            snap_sec_q   <= '0;
            snap_msec_q  <= '0;
            snap_usec_q  <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap;
            if (snap) begin
                snap_sec_q  <= sec_q;
                snap_msec_q <= ms_q;
                snap_usec_q <= us_q;
            end
        end
    end

    assign snap_sec   = snap_sec_q;
    assign snap_msec  = snap_msec_q;
    assign snap_usec  = snap_usec_q;
    assign snap_valid = snap_valid_q;
`endif

endmodule

// File: tb/tb_timebase_gen.sv
// Randomised and directed bench for timebase_gen against an event-count reference model.
module tb_timebase_gen;

    localparam int C   = 4;
    localparam int UPM = 5;
    localparam int MPS = 3;
    localparam int SW  = 2;
    localparam int IW  = 8;

    logic          clk_133m = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [IW-1:0] int_period_ms = '0;
    logic          usec_tick, msec_tick, sec_tick, int_tick;
    logic [SW-1:0] ts_sec;
    logic [1:0]    ts_msec;
    logic [2:0]    ts_usec;
`ifdef TIMEBASE_SNAPSHOT_EN
    logic          snap = 1'b0;
    logic [SW-1:0] snap_sec;
    logic [1:0]    snap_msec;
    logic [2:0]    snap_usec;
    logic          snap_valid;
    logic [SW-1:0] e_ssec;
    logic [1:0]    e_smsec;
    logic [2:0]    e_susec;
    logic          e_sv;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: total enabled edges since clear, plus msec events since last interval tick.
    longint        m_e = 0;
    int            m_ms = 0;
    logic          e_ut, e_mt, e_st, e_it;
    logic [SW-1:0] e_sec;
    logic [1:0]    e_msec;
    logic [2:0]    e_usec;

    timebase_gen #(
        .CLK_PER_USEC(C), .USEC_PER_MSEC(UPM), .MSEC_PER_SEC(MPS), .SEC_W(SW), .INT_W(IW)
    ) dut (
        .clk_133m(clk_133m), .rst(rst), .en(en), .clr(clr), .int_period_ms(int_period_ms),
`ifdef TIMEBASE_SNAPSHOT_EN
        .snap(snap), .snap_sec(snap_sec), .snap_msec(snap_msec), .snap_usec(snap_usec),
        .snap_valid(snap_valid),
`endif
        .usec_tick(usec_tick), .msec_tick(msec_tick), .sec_tick(sec_tick), .int_tick(int_tick),
        .ts_sec(ts_sec), .ts_msec(ts_msec), .ts_usec(ts_usec)
    );

    always #5 clk_133m = ~clk_133m;

    function automatic logic [10:0] got();
        return {usec_tick, msec_tick, sec_tick, int_tick, ts_sec, ts_msec, ts_usec};
    endfunction

    function automatic logic [10:0] expv();
        return {e_ut, e_mt, e_st, e_it, e_sec, e_msec, e_usec};
    endfunction

    task automatic model_edge();
        longint u;
`ifdef TIMEBASE_SNAPSHOT_EN
        if (rst) begin
            e_ssec = '0; e_smsec = '0; e_susec = '0; e_sv = 1'b0;
        end else begin
            e_sv = snap;
            if (snap) begin
                e_ssec = e_sec; e_smsec = e_msec; e_susec = e_usec;
            end
        end
`endif
        e_ut = 1'b0; e_mt = 1'b0; e_st = 1'b0; e_it = 1'b0;
        if (rst || clr) begin
            m_e = 0;
            m_ms = 0;
        end else if (en) begin
            m_e++;
            u = m_e / C;
            e_ut = (m_e % C) == 0;
            e_mt = e_ut && (u % UPM) == 0;
            e_st = e_mt && ((u / UPM) % MPS) == 0;
            if (int_period_ms == 0) m_ms = 0;
            else if (e_mt) begin
                m_ms++;
                if (m_ms >= int'(int_period_ms)) begin
                    e_it = 1'b1;
                    m_ms = 0;
                end
            end
        end
        u = m_e / C;
        e_usec = 3'(u % UPM);
        e_msec = 2'((u / UPM) % MPS);
        e_sec  = SW'((u / (UPM * MPS)) % (1 << SW));
    endtask

    task automatic step();
        @(posedge clk_133m);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1;
        int_period_ms = 8'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (got() !== 11'd0) begin
                fails++;
                $display("FAIL reset cycle %0d: got %b want 0", i, got());
            end
        end
        @(negedge clk_133m);
        rst = 1'b0;
        int_period_ms = '0;
    endtask

    task automatic test_basic();
        for (int n = 1; n <= 70; n++) begin
            step();
            tests++;
            if (got() !== expv()) begin
                fails++;
                $display("FAIL basic edge %0d: got %b want %b", n, got(), expv());
            end
            if (n == 4 || n == 20 || n == 60) begin
                tests++;
                if (!(usec_tick === 1'b1 && msec_tick === (n != 4) && sec_tick === (n == 60))) begin
                    fails++;
                    $display("FAIL basic_strobe edge %0d: got u%b m%b s%b", n, usec_tick, msec_tick, sec_tick);
                end
            end
        end
        // Edge 70 is 10 enabled edges past the first second.
        tests++;
        if ({ts_sec, ts_msec, ts_usec} !== {2'd1, 2'd0, 3'd2}) begin
            fails++;
            $display("FAIL basic_ts: got %0d.%0d.%0d want 1.0.2", ts_sec, ts_msec, ts_usec);
        end
    endtask

    task automatic test_interval();
        clr = 1'b1; step(); clr = 1'b0;
        int_period_ms = 8'd2;
        for (int n = 1; n <= 130; n++) begin
            step();
            tests++;
            if (got() !== expv() || int_tick !== (n % 40 == 0) || (int_tick && !msec_tick)) begin
                fails++;
                $display("FAIL interval edge %0d: got %b want %b", n, got(), expv());
            end
        end
        int_period_ms = '0;
        for (int n = 1; n <= 200; n++) begin
            step();
            tests++;
            if (got() !== expv() || int_tick !== 1'b0) begin
                fails++;
                $display("FAIL interval_off edge %0d: got %b want %b", n, got(), expv());
            end
        end
    endtask

    task automatic test_hold();
        clr = 1'b1; step(); clr = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            en = !(n > 10 && n <= 17);
            step();
            tests++;
            if (got() !== expv() || usec_tick !== (n == 4 || n == 8 || n == 19 || n == 23)) begin
                fails++;
                $display("FAIL hold edge %0d: got %b want %b", n, got(), expv());
            end
        end
        en = 1'b1;
    endtask

    task automatic test_clr();
        clr = 1'b1; step(); clr = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            clr = (n == 33);
            step();
            tests++;
            if (got() !== expv() || (n == 33 && got() !== 11'd0) || (n > 33 && usec_tick !== (n == 37))) begin
                fails++;
                $display("FAIL clr edge %0d: got %b want %b", n, got(), expv());
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_wrap();
        logic [SW-1:0] seen[$];
        logic [SW-1:0] want[4];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
        clr = 1'b1; step(); clr = 1'b0;
        for (int n = 1; n <= 4 * C * UPM * MPS + 5; n++) begin
            step();
            if (sec_tick === 1'b1) seen.push_back(ts_sec);
        end
        tests++;
        if (seen.size() != 4) begin
            fails++;
            $display("FAIL wrap_count: got %0d sec ticks want 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (seen[i] !== want[i]) begin
                    fails++;
                    $display("FAIL wrap_seq[%0d]: got %0d want %0d", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 5) int_period_ms = IW'($urandom_range(0, 4));
`ifdef TIMEBASE_SNAPSHOT_EN
            snap = ($urandom_range(0, 99) < 3);
`endif
            step();
            tests++;
            if (got() !== expv()) begin
                fails++;
                $display("FAIL random edge %0d: got %b want %b", n, got(), expv());
            end
`ifdef TIMEBASE_SNAPSHOT_EN
            tests++;
            if ({snap_valid, snap_sec, snap_msec, snap_usec} !== {e_sv, e_ssec, e_smsec, e_susec}) begin
                fails++;
                $display("FAIL random_snap edge %0d: got %b want %b", n,
                         {snap_valid, snap_sec, snap_msec, snap_usec}, {e_sv, e_ssec, e_smsec, e_susec});
            end
`endif
        end
        en = 1'b1; clr = 1'b0;
`ifdef TIMEBASE_SNAPSHOT_EN
        snap = 1'b0;
`endif
    endtask

`ifdef TIMEBASE_SNAPSHOT_EN
    task automatic test_snapshot();
        int budget = 0;
        clr = 1'b1; step(); clr = 1'b0;
        while (!(ts_msec == 2'd1 && ts_usec == 3'd3) && budget < 200) begin
            step();
            budget++;
        end
        tests++;
        if (budget >= 200) begin
            fails++;
            $display("FAIL snap_wait: timestamp 1.3 not reached within 200 cycles");
        end
        snap = 1'b1; step(); snap = 1'b0;
        tests++;
        if ({snap_valid, snap_msec, snap_usec} !== {1'b1, 2'd1, 3'd3}) begin
            fails++;
            $display("FAIL snap_capture: got v%b %0d.%0d want v1 1.3", snap_valid, snap_msec, snap_usec);
        end
        step();
        tests++;
        if (snap_valid !== 1'b0) begin
            fails++;
            $display("FAIL snap_pulse: got valid %b want 0", snap_valid);
        end
        clr = 1'b1; step(); clr = 1'b0;
        tests++;
        if ({snap_msec, snap_usec, ts_msec, ts_usec} !== {2'd1, 3'd3, 2'd0, 3'd0}) begin
            fails++;
            $display("FAIL snap_after_clr: got snap %0d.%0d ts %0d.%0d want 1.3 0.0",
                     snap_msec, snap_usec, ts_msec, ts_usec);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_interval();
        test_hold();
        test_clr();
        test_wrap();
`ifdef TIMEBASE_SNAPSHOT_EN
        test_snapshot();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
